// File: rtl/emesh_txwr_burst.sv
// Write-burst generator for the elink txwr port: turns one burst command into
// count emesh write packets, honouring txwr_wait back-pressure.
module emesh_txwr_burst #(
  parameter int             PW      = 104,
  parameter int             AW      = 32,
  parameter int             CW      = 16,
  parameter logic [AW-1:0]  SRCADDR = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_dstaddr,
  input  logic [AW-1:0] cmd_data,
  input  logic [CW-1:0] cmd_count,
  input  logic [1:0]    cmd_datamode,
  input  logic [4:0]    cmd_ctrlmode,
  output logic          txwr_access,
  output logic [PW-1:0] txwr_packet,
  input  logic          txwr_wait,
  output logic          busy,
  output logic          burst_done,
  output logic          burst_error
);

  localparam int MODE_LSB = 1;
  localparam int ADDR_LSB = 8;
  localparam int DATA_LSB = ADDR_LSB + AW;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] remain_p0;
  logic          load, advance, finish, reject, empty;

  logic [AW-1:0] pkt_addr, pkt_data;
  logic [1:0]    pkt_mode;

  function automatic logic is_aligned(input logic [AW-1:0] addr, input logic [1:0] mode);
    case (mode)
      2'd1:    is_aligned = (addr[0] == 1'b0);
      2'd2:    is_aligned = (addr[1:0] == 2'b00);
      2'd3:    is_aligned = (addr[2:0] == 3'b000);
      default: is_aligned = 1'b1;
    endcase
  endfunction

  function automatic logic [AW-1:0] addr_step(input logic [1:0] mode);
    addr_step = AW'(1) << mode;
  endfunction

  // The outgoing packet register is also the burst's address/data state.
  assign pkt_addr = txwr_packet[ADDR_LSB +: AW];
  assign pkt_data = txwr_packet[DATA_LSB +: AW];
  assign pkt_mode = txwr_packet[MODE_LSB +: 2];

  assign cmd_ready = (state == IDLE) && !reset;
  assign busy      = (state == SEND);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    reject    = 1'b0;
    empty     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (!is_aligned(cmd_dstaddr, cmd_datamode)) begin
            reject = 1'b1;
          end else if (cmd_count == '0) begin
            empty = 1'b1;
          end else begin
            load      = 1'b1;
            state_nxt = SEND;
          end
        end
      end
      SEND: begin
        if (!txwr_wait) begin
          if (remain_p0 == '0) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      txwr_access <= 1'b0;
      burst_done  <= 1'b0;
      burst_error <= 1'b0;
      txwr_packet <= '0;
    end else begin
      burst_done  <= empty | finish;
      burst_error <= reject;
      if (load)        txwr_access <= 1'b1;
      else if (finish) txwr_access <= 1'b0;
      if (load) begin
        txwr_packet <= {SRCADDR, cmd_data, cmd_dstaddr, cmd_ctrlmode, cmd_datamode, 1'b1};
      end else if (advance) begin
        txwr_packet[DATA_LSB +: AW] <= pkt_data + AW'(1);
        txwr_packet[ADDR_LSB +: AW] <= pkt_addr + addr_step(pkt_mode);
      end
    end
  end

  // remain_p0 counts packets still to follow the one currently presented.
  always_ff @(posedge clock) begin
    if (load)         remain_p0 <= cmd_count - CW'(1);
    else if (advance) remain_p0 <= remain_p0 - CW'(1);
  end

endmodule
